// File: rtl/mdu_iterative_if.sv
// Operand/result bundle between the multicycle control path and the iterative MDU.
interface mdu_iterative_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [1:0]       Op;
  logic             Signed;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (output Start, Op, Signed, SrcA, SrcB, input Busy, Done, HI, LO);
  modport slave  (input Start, Op, Signed, SrcA, SrcB, output Busy, Done, HI, LO);
endinterface

// File: rtl/mdu_iterative.sv
// Iterative shift-add multiplier / restoring divider with HI/LO registers.
// Define MDU_SIGNED_EN to build the two's-complement (Signed=1) MULT/DIV path.
module mdu_iterative #(
  parameter int WIDTH = 32,
  parameter int CNTW  = $clog2(WIDTH) + 1
) (
  input logic            CLK,
  input logic            Reset,
  mdu_iterative_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;

  state_e              state_q, state_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]    hi_q, hi_d;
  logic [WIDTH-1:0]    lo_q, lo_d;
  logic                is_div_q, is_div_d;
  logic                dz_q, dz_d;
  logic [2*WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]    rem_q, rem_d;
  logic [WIDTH-1:0]    opb_q, opb_d;

  logic [WIDTH-1:0]    a_mag, b_mag;
  logic [WIDTH:0]      msum;
  logic [2*WIDTH-1:0]  mul_nxt, prod_fix;
  logic [WIDTH:0]      div_sh, div_diff;
  logic                qbit;
  logic [WIDTH-1:0]    rem_nxt, quo_nxt, quo_fix, rem_fix;

`ifdef MDU_SIGNED_EN
  logic neg_q, neg_d;
  logic negr_q, negr_d;
  logic sa, sb;

  function automatic logic [WIDTH-1:0] cneg_w(input logic [WIDTH-1:0] v, input logic n);
    return n ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cneg_2w(input logic [2*WIDTH-1:0] v, input logic n);
    return n ? (~v + (2*WIDTH)'(1)) : v;
  endfunction

  assign sa       = bus.Signed & bus.SrcA[WIDTH-1];
  assign sb       = bus.Signed & bus.SrcB[WIDTH-1];
  assign a_mag    = cneg_w(bus.SrcA, sa);
  assign b_mag    = cneg_w(bus.SrcB, sb);
  assign prod_fix = cneg_2w(mul_nxt, neg_q);
  assign quo_fix  = cneg_w(quo_nxt, neg_q);
  // Remainder follows the dividend's sign; MIN/-1 wraps back to MIN naturally.
  assign rem_fix  = cneg_w(rem_nxt, negr_q);
`else
  assign a_mag    = bus.SrcA;
  assign b_mag    = bus.SrcB;
  assign prod_fix = mul_nxt;
  assign quo_fix  = quo_nxt;
  assign rem_fix  = rem_nxt;
`endif

  // Multiply step: add multiplicand into the upper half, shift {hi,lo} right.
  assign msum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : '0)};
  assign mul_nxt = {msum, acc_q[WIDTH-1:1]};

  // Restoring divide step: dividend bits shift out of acc, quotient bits shift in.
  assign div_sh   = {rem_q, acc_q[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, opb_q};
  assign qbit     = ~div_diff[WIDTH];
  assign rem_nxt  = qbit ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
  assign quo_nxt  = {acc_q[WIDTH-2:0], qbit};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    dz_d     = dz_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    opb_d    = opb_q;
`ifdef MDU_SIGNED_EN
    neg_d    = neg_q;
    negr_d   = negr_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          if (bus.Op == OP_MTHI) begin
            hi_d = bus.SrcA;
          end else if (bus.Op == OP_MTLO) begin
            lo_d = bus.SrcA;
          end else begin
            state_d  = S_RUN;
            cnt_d    = '0;
            is_div_d = (bus.Op == OP_DIV);
            dz_d     = (bus.SrcB == '0);
            rem_d    = '0;
            acc_d    = {{WIDTH{1'b0}}, ((bus.Op == OP_DIV) ? a_mag : b_mag)};
            opb_d    = (bus.Op == OP_DIV) ? b_mag : a_mag;
`ifdef MDU_SIGNED_EN
            neg_d    = sa ^ sb;
            negr_d   = sa;
`endif
          end
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + CNTW'(1);
        if (is_div_q) begin
          acc_d = {acc_q[2*WIDTH-1:WIDTH], quo_nxt};
          rem_d = rem_nxt;
        end else begin
          acc_d = mul_nxt;
        end
        if (cnt_q == CNTW'(WIDTH - 1)) begin
          state_d = S_DONE;
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = dz_q ? '1 : quo_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Datapath working registers are fully reloaded at Start, so they carry no reset.
  always_ff @(posedge CLK) begin
    is_div_q <= is_div_d;
    dz_q     <= dz_d;
    acc_q    <= acc_d;
    rem_q    <= rem_d;
    opb_q    <= opb_d;
`ifdef MDU_SIGNED_EN
    neg_q    <= neg_d;
    negr_q   <= negr_d;
`endif
  end

  assign bus.Busy = (state_q != S_IDLE);
  assign bus.Done = (state_q == S_DONE);
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Scoreboard bench for mdu_iterative: stimulus queues expectations, a negedge monitor checks them.
module tb_mdu_iterative;

  localparam int W = 32;
  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic end_req = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  string          dq_name[$];
  logic [63:0]    dq_act[$];
  logic [63:0]    dq_exp[$];
  int             sb_start[$];
  logic [W-1:0]   sb_hi[$];
  logic [W-1:0]   sb_lo[$];

  mdu_iterative_if #(.WIDTH(W)) bus ();

  mdu_iterative #(.WIDTH(W)) dut (
    .CLK  (clk),
    .Reset(rst),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_eq(input string n, input logic [63:0] act, input logic [63:0] exp);
    dq_name.push_back(n);
    dq_act.push_back(act);
    dq_exp.push_back(exp);
  endtask

  // Drives one Start cycle; for MULT/DIV the expected HI/LO is queued with the start cycle.
  task automatic issue(input logic [1:0] op, input logic sgn, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el);
    bus.Start  = 1'b1;
    bus.Op     = op;
    bus.Signed = sgn;
    bus.SrcA   = a;
    bus.SrcB   = b;
    tick();
    bus.Start  = 1'b0;
    if (op == OP_MULT || op == OP_DIV) begin
      sb_start.push_back(cyc);
      sb_hi.push_back(eh);
      sb_lo.push_back(el);
    end
  endtask

  task automatic wait_idle(input string n);
    for (int i = 0; i < 100; i++) begin
      if (bus.Busy === 1'b0) break;
      tick();
    end
    expect_eq(n, {63'd0, bus.Busy}, 64'd0);
  endtask

  // Monitor / scoreboard
  initial begin
    string        n;
    logic [63:0]  a, e;
    int           s;
    logic [W-1:0] h, l;
    forever begin
      @(negedge clk);
      while (dq_name.size() > 0) begin
        n = dq_name.pop_front();
        a = dq_act.pop_front();
        e = dq_exp.pop_front();
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL %s: got %h expected %h", n, a, e);
        end
      end
      if (bus.Done === 1'b1) begin
        checks++;
        if (sb_hi.size() == 0) begin
          failures++;
          $display("FAIL unexpected_done: got Done=1 expected Done=0 at cycle %0d", cyc);
        end else begin
          s = sb_start.pop_front();
          h = sb_hi.pop_front();
          l = sb_lo.pop_front();
          if (cyc - s != W) begin
            failures++;
            $display("FAIL done_latency: got %0d edges expected %0d", cyc - s, W);
          end
          checks++;
          if (bus.HI !== h) begin
            failures++;
            $display("FAIL result_hi: got %h expected %h", bus.HI, h);
          end
          checks++;
          if (bus.LO !== l) begin
            failures++;
            $display("FAIL result_lo: got %h expected %h", bus.LO, l);
          end
          checks++;
          if (bus.Busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_at_done: got %b expected 1", bus.Busy);
          end
        end
      end
      if (end_req) begin
        checks++;
        if (sb_hi.size() != 0) begin
          failures++;
          $display("FAIL missing_done: got %0d pending expected 0", sb_hi.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  end

  // Stimulus
  initial begin
    bus.Start = 1'b0; bus.Op = 2'b00; bus.Signed = 1'b0;
    bus.SrcA = '0; bus.SrcB = '0;
    rst = 1'b1;
    tick(); tick();
    expect_eq("reset_hi",   {32'd0, bus.HI}, 64'd0);
    expect_eq("reset_lo",   {32'd0, bus.LO}, 64'd0);
    expect_eq("reset_busy", {63'd0, bus.Busy}, 64'd0);
    expect_eq("reset_done", {63'd0, bus.Done}, 64'd0);
    rst = 1'b0;
    tick();

    // Largest unsigned product
    issue(OP_MULT, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    expect_eq("busy_rise", {63'd0, bus.Busy}, 64'd1);
    wait_idle("mult_idle");

    // HI/LO hold the previous product while the divide runs
    issue(OP_DIV, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14);
    for (int i = 0; i < 10; i++) tick();
    expect_eq("hold_hi", {32'd0, bus.HI}, {32'd0, 32'hFFFFFFFE});
    expect_eq("hold_lo", {32'd0, bus.LO}, 64'd1);
    expect_eq("busy_run", {63'd0, bus.Busy}, 64'd1);
    wait_idle("div_idle");

    issue(OP_DIV, 1'b0, 32'h00001234, 32'd0, 32'h00001234, 32'hFFFFFFFF);
    wait_idle("divz_idle");

    // Single-cycle moves on consecutive edges
    issue(OP_MTHI, 1'b0, 32'hDEADBEEF, 32'd0, 32'd0, 32'd0);
    expect_eq("mthi_hi",   {32'd0, bus.HI}, {32'd0, 32'hDEADBEEF});
    expect_eq("mthi_lo",   {32'd0, bus.LO}, {32'd0, 32'hFFFFFFFF});
    expect_eq("mthi_busy", {63'd0, bus.Busy}, 64'd0);
    issue(OP_MTLO, 1'b0, 32'hCAFEF00D, 32'd0, 32'd0, 32'd0);
    expect_eq("mtlo_lo",   {32'd0, bus.LO}, {32'd0, 32'hCAFEF00D});
    expect_eq("mtlo_hi",   {32'd0, bus.HI}, {32'd0, 32'hDEADBEEF});
    expect_eq("mtlo_busy", {63'd0, bus.Busy}, 64'd0);
    expect_eq("mtlo_done", {63'd0, bus.Done}, 64'd0);
    tick();

    // Start during RUN must be ignored
    issue(OP_MULT, 1'b0, 32'd3, 32'd5, 32'd0, 32'd15);
    for (int i = 0; i < 5; i++) tick();
    bus.Start = 1'b1; bus.Op = OP_DIV; bus.SrcA = 32'd9; bus.SrcB = 32'd4;
    tick();
    bus.Start = 1'b0;
    expect_eq("ignore_hold_lo", {32'd0, bus.LO}, {32'd0, 32'hCAFEF00D});
    wait_idle("ignore_idle");

    // Reset mid-RUN aborts without Done
    issue(OP_MULT, 1'b0, 32'd7, 32'd9, 32'd0, 32'd0);
    void'(sb_hi.pop_back()); void'(sb_lo.pop_back()); void'(sb_start.pop_back());
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    expect_eq("abort_hi",   {32'd0, bus.HI}, 64'd0);
    expect_eq("abort_lo",   {32'd0, bus.LO}, 64'd0);
    expect_eq("abort_busy", {63'd0, bus.Busy}, 64'd0);
    expect_eq("abort_done", {63'd0, bus.Done}, 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) tick();

    // Carry across the HI/LO boundary; top-bit dividend over max divisor
    issue(OP_MULT, 1'b0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000);
    wait_idle("carry_idle");
    issue(OP_DIV, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000);
    wait_idle("udivmax_idle");
    tick();
    issue(OP_DIV, 1'b1, 32'hFFFFFFF9, 32'd2,
`ifdef MDU_SIGNED_EN
          32'hFFFFFFFF, 32'hFFFFFFFD);
`else
          32'h00000001, 32'h7FFFFFFC);
`endif
    wait_idle("sgnflag_idle");

`ifdef MDU_SIGNED_EN
    issue(OP_MULT, 1'b1, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
    wait_idle("smul_idle");
    issue(OP_DIV, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    wait_idle("sdivmin_idle");
    issue(OP_DIV, 1'b1, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF);
    wait_idle("sdivz_idle");
`endif

    tick(); tick();
    end_req = 1'b1;
  end

endmodule

// File: doc/mdu_iterative.md
Name: mdu_iterative

Overview:
- Parametrised iterative multiply/divide unit with HI/LO result registers for the multicycle MIPS datapath.
- Executes MULT/MULTU/DIV/DIVU over WIDTH cycles and MTHI/MTLO in a single cycle.
- Exposes Busy/Done so the control FSM stalls MFHI/MFLO and new MDU ops.
- Operands come from the register-file read ports (rs, rt); HI/LO feed the result mux.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; product is 2*WIDTH bits.
- CNTW, $clog2(WIDTH)+1, iteration counter width.

Ports:
- CLK  input  1  clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  launch operation; sampled only in IDLE.
- Op  input  2  00 MULT, 01 DIV, 10 MTHI, 11 MTLO.
- Signed  input  1  1 = signed MULT/DIV (see Optional Feature).
- SrcA  input  WIDTH  rs: multiplicand/dividend, or MTHI/MTLO data.
- SrcB  input  WIDTH  rt: multiplier/divisor.
- Busy  output  1  high while state is RUN or DONE.
- Done  output  1  one-cycle pulse, HI/LO valid.
- HI  output  WIDTH  HI register.
- LO  output  WIDTH  LO register.

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-high.
- Reset: state IDLE, HI=0, LO=0, Busy=0, Done=0, counter=0. Reset mid-operation aborts it and discards partial results.
- States: IDLE, RUN, DONE.
- IDLE, Start=1, Op=MTHI/MTLO: write SrcA into HI/LO at that edge. Stay in IDLE; no Busy, no Done.
- IDLE, Start=1, Op=MULT/DIV: latch operands (magnitudes if signed), record op and result signs, counter=0. Go to RUN.
- RUN, MULT: shift-add, one multiplier bit per cycle, 2*WIDTH-bit accumulator.
- RUN, DIV: restoring division, one quotient bit per cycle, WIDTH+1-bit partial remainder.
- RUN: counter increments each cycle. On the edge where counter==WIDTH-1, apply sign fix and write HI/LO, then go to DONE.
  - MULT: HI=product[2W-1:W], LO=product[W-1:0].
  - DIV: LO=quotient, HI=remainder.
- DONE: Done=1 for exactly one cycle, then IDLE.
- Latency: Start at edge k; Busy high for cycles k+1..k+WIDTH+1; Done high in cycle k+WIDTH+1. A new Start is accepted in the cycle after Done.
- Start while Busy: ignored; no effect on state, operands or HI/LO.
- HI/LO hold their previous values throughout RUN. They change only on MTHI/MTLO, on the RUN->DONE edge, or on Reset.
- Divide by zero: LO=all ones, HI=SrcA as latched. Latency is unchanged; no exception.
- Unsigned multiply: full 2*WIDTH-bit product, never overflows.

Optional Feature:
- Macro: MDU_SIGNED_EN.
- Defined, Signed=1: operands are two's complement and magnitudes are taken at Start.
  - Product is negated if the signs differ.
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - MIN/-1 gives LO=MIN, HI=0.
  - Divide by zero gives LO=all ones, HI=SrcA.
- Not defined: Signed is ignored and all MULT/DIV are unsigned; no sign-fix logic is built.

Test Plan (WIDTH=32):
- Reset, then MULT unsigned 0xFFFFFFFF*0xFFFFFFFF -> Busy rises next cycle; Done exactly 33 cycles after Start edge; HI=0xFFFFFFFE, LO=0x00000001.
- DIV unsigned 100/7 -> LO=14, HI=2; HI/LO keep prior values until the Done cycle.
- DIV 0x1234/0 -> LO=0xFFFFFFFF, HI=0x00001234, same 33-cycle latency.
- MTHI 0xDEADBEEF then MTLO 0xCAFEF00D on consecutive cycles -> HI/LO update at each edge; Busy and Done stay 0.
- Start pulsed mid-RUN with different operands -> ignored, original result returned; Reset asserted mid-RUN -> HI=LO=0, Busy=0 next cycle, no Done.
- With MDU_SIGNED_EN:
  - MULT -3*5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
  - DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
